// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer that drives an external 8-bit ALU for one command at a time.
// Optional feature macro ALU_SEQ_NMOS_FLAGS_EN: decimal ADC/SBC take N/Z from the unadjusted pass-1 sum.
module alu_seq #(
  parameter logic [7:0] DEC_ADJ_ADD = 8'h66,
  parameter logic [7:0] DEC_ADJ_SUB = 8'h9A
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] cmd,
  input  logic [7:0] a_in,
  input  logic [7:0] m_in,
  input  logic       c_in,
  input  logic       d_flag,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       n_out,
  output logic       z_out,
  output logic       v_out,
  output logic [7:0] alu_ai,
  output logic [7:0] alu_mi,
  output logic       alu_ci,
  output logic       alu_mem_bi,
  output logic       alu_inv_bi,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_adj_lsd,
  input  logic       alu_adj_msd
);

  localparam logic [2:0] ALU_ADC = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_ORA = 3'd2;
  localparam logic [2:0] ALU_EOR = 3'd3;
  localparam logic [2:0] ALU_ROL = 3'd4;
  localparam logic [2:0] ALU_ROR = 3'd5;
  localparam logic [2:0] ALU_AI  = 3'd6;

  localparam logic [3:0] CMD_ADC = 4'd0;
  localparam logic [3:0] CMD_SBC = 4'd1;
  localparam logic [3:0] CMD_CMP = 4'd2;
  localparam logic [3:0] CMD_AND = 4'd3;
  localparam logic [3:0] CMD_ORA = 4'd4;
  localparam logic [3:0] CMD_EOR = 4'd5;
  localparam logic [3:0] CMD_ASL = 4'd6;
  localparam logic [3:0] CMD_ROL = 4'd7;
  localparam logic [3:0] CMD_LSR = 4'd8;
  localparam logic [3:0] CMD_ROR = 4'd9;
  localparam logic [3:0] CMD_INC = 4'd10;
  localparam logic [3:0] CMD_DEC = 4'd11;

  // Single-digit corrections; the subtract forms are -6 and -0x60 modulo 256.
  localparam logic [7:0] ADJ_ADD_LSD = DEC_ADJ_ADD & 8'h0F;
  localparam logic [7:0] ADJ_ADD_MSD = DEC_ADJ_ADD & 8'hF0;
  localparam logic [7:0] ADJ_SUB_LSD = 8'hFA;
  localparam logic [7:0] ADJ_SUB_MSD = 8'hA0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_cmd_lat;
  logic [7:0] r_a_lat;
  logic [7:0] r_m_lat;
  logic       r_c_lat;
  logic       r_d_lat;
  logic [7:0] r_tmp;
  logic       r_tmp_c;
  logic       r_tmp_v;
  logic       r_adj_lsd;
  logic       r_adj_msd;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_result;
  logic       r_c_flag;
  logic       r_n_flag;
  logic       r_z_flag;
  logic       r_v_flag;

  logic       w_is_nop;
  logic       w_is_dec;
  logic       w_is_sub;
  logic [7:0] w_adj_const;
  logic [2:0] w_op;
  logic [7:0] w_ai;
  logic [7:0] w_mi;
  logic       w_ci;
  logic       w_mem;
  logic       w_inv;

  assign w_is_nop = r_cmd_lat[3] & r_cmd_lat[2];
  assign w_is_sub = (r_cmd_lat == CMD_SBC);
  assign w_is_dec = r_d_lat & ((r_cmd_lat == CMD_ADC) | (r_cmd_lat == CMD_SBC));

  always_comb begin
    w_adj_const = 8'h00;
    case ({r_adj_msd, r_adj_lsd})
      2'b01:   w_adj_const = w_is_sub ? ADJ_SUB_LSD : ADJ_ADD_LSD;
      2'b10:   w_adj_const = w_is_sub ? ADJ_SUB_MSD : ADJ_ADD_MSD;
      2'b11:   w_adj_const = w_is_sub ? DEC_ADJ_SUB : DEC_ADJ_ADD;
      default: w_adj_const = 8'h00;
    endcase
  end

  // ALU drive is decoded from the state and the operand latches only.
  always_comb begin
    w_op  = ALU_AI;
    w_ai  = 8'h00;
    w_mi  = 8'h00;
    w_ci  = 1'b0;
    w_mem = 1'b0;
    w_inv = 1'b0;
    case (r_state)
      S_PASS1: begin
        if (!w_is_nop) begin
          w_ai = r_a_lat;
          w_mi = r_m_lat;
        end
        case (r_cmd_lat)
          CMD_ADC: begin w_op = ALU_ADC; w_mem = 1'b1; w_ci = r_c_lat; end
          CMD_SBC: begin w_op = ALU_ADC; w_mem = 1'b1; w_inv = 1'b1; w_ci = r_c_lat; end
          CMD_CMP: begin w_op = ALU_ADC; w_mem = 1'b1; w_inv = 1'b1; w_ci = 1'b1; end
          CMD_AND: begin w_op = ALU_AND; w_mem = 1'b1; end
          CMD_ORA: begin w_op = ALU_ORA; w_mem = 1'b1; end
          CMD_EOR: begin w_op = ALU_EOR; w_mem = 1'b1; end
          CMD_ASL: begin w_op = ALU_ROL; w_ci = 1'b0; end
          CMD_ROL: begin w_op = ALU_ROL; w_ci = r_c_lat; end
          CMD_LSR: begin w_op = ALU_ROR; w_ci = 1'b0; end
          CMD_ROR: begin w_op = ALU_ROR; w_ci = r_c_lat; end
          CMD_INC: begin w_op = ALU_ADC; w_ai = r_m_lat; w_ci = 1'b1; end
          CMD_DEC: begin w_op = ALU_ADC; w_ai = r_m_lat; w_inv = 1'b1; w_ci = 1'b0; end
          default: w_op = ALU_AI;
        endcase
      end
      S_PASS2: begin
        w_op  = ALU_ADC;
        w_ai  = r_tmp;
        w_mi  = w_adj_const;
        w_mem = 1'b1;
      end
      default: w_op = ALU_AI;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cmd_lat <= 4'd0;
      r_a_lat   <= 8'h00;
      r_m_lat   <= 8'h00;
      r_c_lat   <= 1'b0;
      r_d_lat   <= 1'b0;
      r_tmp     <= 8'h00;
      r_tmp_c   <= 1'b0;
      r_tmp_v   <= 1'b0;
      r_adj_lsd <= 1'b0;
      r_adj_msd <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 8'h00;
      r_c_flag  <= 1'b0;
      r_n_flag  <= 1'b0;
      r_z_flag  <= 1'b0;
      r_v_flag  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cmd_lat <= cmd;
            r_a_lat   <= a_in;
            r_m_lat   <= m_in;
            r_c_lat   <= c_in;
            r_d_lat   <= d_flag;
            r_busy    <= 1'b1;
            r_state   <= S_PASS1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PASS1: begin
          if (!w_is_nop) begin
            r_tmp     <= alu_out;
            r_tmp_c   <= alu_c;
            r_tmp_v   <= alu_v;
            r_adj_lsd <= alu_adj_lsd;
            r_adj_msd <= alu_adj_msd;
          end
          if (w_is_dec) begin
            r_state <= S_PASS2;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            case (r_cmd_lat)
              CMD_ADC, CMD_SBC: begin
                r_result <= alu_out;
                r_c_flag <= alu_c;
                r_n_flag <= alu_n;
                r_z_flag <= alu_z;
                r_v_flag <= alu_v;
              end
              CMD_CMP: begin
                r_c_flag <= alu_c;
                r_n_flag <= alu_n;
                r_z_flag <= alu_z;
              end
              CMD_ASL, CMD_ROL, CMD_LSR, CMD_ROR: begin
                r_result <= alu_out;
                r_c_flag <= alu_c;
                r_n_flag <= alu_n;
                r_z_flag <= alu_z;
              end
              CMD_AND, CMD_ORA, CMD_EOR, CMD_INC, CMD_DEC: begin
                r_result <= alu_out;
                r_n_flag <= alu_n;
                r_z_flag <= alu_z;
              end
              default: ;
            endcase
          end
        end
        S_PASS2: begin
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= alu_out;
          // Decimal add carries out of the tens digit; decimal subtract keeps the binary borrow.
          r_c_flag <= w_is_sub ? r_tmp_c : r_adj_msd;
          r_v_flag <= r_tmp_v;
`ifdef ALU_SEQ_NMOS_FLAGS_EN
          r_n_flag <= r_tmp[7];
          r_z_flag <= (r_tmp == 8'h00);
`else
          r_n_flag <= alu_n;
          r_z_flag <= alu_z;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign c_out      = r_c_flag;
  assign n_out      = r_n_flag;
  assign z_out      = r_z_flag;
  assign v_out      = r_v_flag;
  assign alu_op     = w_op;
  assign alu_ai     = w_ai;
  assign alu_mi     = w_mi;
  assign alu_ci     = w_ci;
  assign alu_mem_bi = w_mem;
  assign alu_inv_bi = w_inv;

endmodule
